// File: rtl/scratchpad_ex_loader_if.sv
// -----------------------------------------------------------------------------
// scratchpad_ex_loader_if
// Bundles the command channel, the upstream write stream and the scratchpad
// external-port outputs of scratchpad_ex_loader.
//   cmd_*   : command offer (valid/ready) with op, base, length and BG mask
//   s_*     : 32-bit write-data stream (valid/ready)
//   ex_bus  : {ex_wen, ex_ren, ex_addr, ex_data} towards the scratchpad
//   inst_out: {BG_en[3:0], BG_sel[3:0], BG_mode[3:0]} towards the scratchpad
//   busy    : a command is in progress
//   done    : one-cycle pulse after the last beat has been driven
// Modports: master = host/DMA side, slave = the loader itself.
// -----------------------------------------------------------------------------
interface scratchpad_ex_loader_if #(
    parameter int A_W   = 10,
    parameter int D_W   = 32,
    parameter int LEN_W = 11
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_op;
    logic [A_W-1:0]         cmd_base;
    logic [LEN_W-1:0]       cmd_len;
    logic [3:0]             cmd_bg_mask;
    logic                   s_valid;
    logic                   s_ready;
    logic [D_W-1:0]         s_data;
    logic [2+A_W+D_W-1:0]   ex_bus;
    logic [11:0]            inst_out;
    logic                   busy;
    logic                   done;

    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_len, cmd_bg_mask, s_valid, s_data,
        input  cmd_ready, s_ready, ex_bus, inst_out, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_len, cmd_bg_mask, s_valid, s_data,
        output cmd_ready, s_ready, ex_bus, inst_out, busy, done
    );
endinterface

// File: rtl/scratchpad_ex_loader.sv
// -----------------------------------------------------------------------------
// scratchpad_ex_loader
// Initiator for the scratchpad external port. One command at a time:
//   op=0 : copies cmd_len beats from the s_* stream to consecutive addresses
//   op=1 : issues cmd_len back-to-back reads (data returns elsewhere)
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : scratchpad_ex_loader_if.slave (command, stream, ex_bus, inst_out,
//          busy, done)
// Every output comes straight from a flop. The FSM walks IDLE -> ARM -> XFER ->
// DONE; ARM holds the bank-group enables for one quiet cycle before the first
// access. Addresses wrap modulo 2^A_W.
// -----------------------------------------------------------------------------
module scratchpad_ex_loader #(
    parameter int A_W   = 10,
    parameter int D_W   = 32,
    parameter int LEN_W = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    scratchpad_ex_loader_if.slave  bus
);
    localparam int EX_W = 2 + A_W + D_W;
    localparam logic [A_W-1:0]   ADDR_ONE = A_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              op_q, op_d;
    logic [A_W-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [3:0]        bg_en_q, bg_en_d;
    logic [EX_W-1:0]   ex_bus_q, ex_bus_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Packs one external-port beat in {wen, ren, addr, data} order.
    function automatic logic [EX_W-1:0] ex_beat(input logic wen, input logic ren,
                                                input logic [A_W-1:0] addr,
                                                input logic [D_W-1:0] data);
        return {wen, ren, addr, data};
    endfunction

    // Next-state and next-output computation; outputs are staged one cycle
    // ahead so that what is registered is what the scratchpad sees.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        bg_en_d  = bg_en_q;
        ex_bus_d = {EX_W{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d    = bus.cmd_op;
                    addr_d  = bus.cmd_base;
                    rem_d   = bus.cmd_len;
                    bg_en_d = bus.cmd_bg_mask;
                    state_d = (bus.cmd_len == LEN_ZERO) ? ST_DONE : ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                state_d = ST_XFER;
                // Reads have no input dependency, so the first read is staged
                // here and appears in the first XFER cycle.
                if (op_q) begin
                    ex_bus_d = ex_beat(1'b0, 1'b1, addr_q, {D_W{1'b0}});
                    addr_d   = addr_q + ADDR_ONE;
                    rem_d    = rem_q - LEN_ONE;
                end else begin
                    ex_bus_d = {EX_W{1'b0}};
                end
            end
            ST_XFER: begin
                // remaining==0 here means the final beat is on ex_bus now.
                if (rem_q == LEN_ZERO) begin
                    state_d = ST_DONE;
                end else if (op_q) begin
                    ex_bus_d = ex_beat(1'b0, 1'b1, addr_q, {D_W{1'b0}});
                    addr_d   = addr_q + ADDR_ONE;
                    rem_d    = rem_q - LEN_ONE;
                end else if (s_ready_q && bus.s_valid) begin
                    ex_bus_d = ex_beat(1'b1, 1'b0, addr_q, bus.s_data);
                    addr_d   = addr_q + ADDR_ONE;
                    rem_d    = rem_q - LEN_ONE;
                end else begin
                    ex_bus_d = {EX_W{1'b0}};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bank groups stay enabled only through ARM and XFER.
        if ((state_d == ST_DONE) || (state_d == ST_IDLE)) begin
            bg_en_d = 4'b0000;
        end else begin
            bg_en_d = bg_en_d;
        end

        busy_d      = (state_d != ST_IDLE);
        cmd_ready_d = (state_d == ST_IDLE);
        done_d      = (state_d == ST_DONE);
        // Drops as soon as the last beat is taken, never offering an extra one.
        s_ready_d   = (state_d == ST_XFER) && !op_d && (rem_d != LEN_ZERO);
    end

    // State and output registers; reset clears every output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 1'b0;
            addr_q      <= {A_W{1'b0}};
            rem_q       <= {LEN_W{1'b0}};
            bg_en_q     <= 4'b0000;
            ex_bus_q    <= {EX_W{1'b0}};
            cmd_ready_q <= 1'b0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            bg_en_q     <= bg_en_d;
            ex_bus_q    <= ex_bus_d;
            cmd_ready_q <= cmd_ready_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.s_ready   = s_ready_q;
    assign bus.ex_bus    = ex_bus_q;
    // BG_sel and BG_mode are tied low: external path, default mode.
    assign bus.inst_out  = {bg_en_q, 4'b0000, 4'b0000};
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_scratchpad_ex_loader.sv
module tb_scratchpad_ex_loader;
    localparam int A_W   = 10;
    localparam int D_W   = 32;
    localparam int LEN_W = 11;
    localparam int EX_W  = 2 + A_W + D_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scratchpad_ex_loader_if #(.A_W(A_W), .D_W(D_W), .LEN_W(LEN_W)) bus ();

    scratchpad_ex_loader #(.A_W(A_W), .D_W(D_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected external-port beat, address reduced modulo 2^A_W.
    function automatic logic [EX_W-1:0] mk(input logic w, input logic r, input int a,
                                           input logic [31:0] d);
        int m;
        m = a % (1 << A_W);
        return {w, r, m[A_W-1:0], d};
    endfunction

    // Runs one command and checks every cycle against a cycle-indexed model:
    // k=1 is the ARM cycle (or DONE for len=0); reads occupy k=2..len+1; a
    // write beat accepted in cycle k is on ex_bus in cycle k+1.
    // mode: 0 stream always valid, 1 toggling from first XFER cycle, 2 random.
    task automatic run_cmd(input bit op, input int base, input int len, input logic [3:0] mask,
                           input int mode, input logic [31:0] seed, input bit hold,
                           input int abort_after);
        int k, acc, drv, done_cyc, pend_idx, bound;
        bit pend, sv, finished, exp_busy, exp_done, exp_sr;
        logic [EX_W-1:0] exp_ex;
        logic [3:0] exp_bg;

        for (int w = 0; w < 50 && bus.cmd_ready !== 1'b1; w++) @(negedge clk);
        check("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);

        bus.cmd_op      = op;
        bus.cmd_base    = base[A_W-1:0];
        bus.cmd_len     = len[LEN_W-1:0];
        bus.cmd_bg_mask = mask;
        bus.cmd_valid   = 1'b1;
        bus.s_valid     = (mode == 0);
        bus.s_data      = seed;
        @(posedge clk);
        #1 bus.cmd_valid = hold;

        acc = 0; drv = 0; pend = 1'b0; pend_idx = 0; finished = 1'b0; k = 0;
        done_cyc = (len == 0) ? 1 : (op ? len + 2 : -1);
        bound = 8 * len + 16;

        while (!finished && k < bound) begin
            k++;
            @(negedge clk);
            exp_busy = (done_cyc < 0) || (k <= done_cyc);
            exp_done = (k == done_cyc);
            exp_bg   = (exp_busy && !exp_done) ? mask : 4'h0;
            exp_sr   = !op && (k >= 2) && (acc < len);
            if (op)
                exp_ex = (k >= 2 && k <= len + 1) ? mk(1'b0, 1'b1, base + k - 2, 32'h0) : '0;
            else
                exp_ex = pend ? mk(1'b1, 1'b0, base + pend_idx, seed + 32'(pend_idx)) : '0;
            if (pend) drv++;

            check("ex_bus",    64'(bus.ex_bus),    64'(exp_ex));
            check("inst_out",  64'(bus.inst_out),  64'({exp_bg, 8'h00}));
            check("busy",      64'(bus.busy),      64'(exp_busy));
            check("done",      64'(bus.done),      64'(exp_done));
            check("s_ready",   64'(bus.s_ready),   64'(exp_sr));
            check("cmd_ready", 64'(bus.cmd_ready), 64'(!exp_busy));

            if (done_cyc >= 0 && k == done_cyc + 1) begin
                finished = 1'b1;
            end else if (abort_after > 0 && drv == abort_after) begin
                rst = 1'b1;
                bus.s_valid = 1'b0;
                bus.cmd_valid = 1'b0;
                @(negedge clk);
                check("abort_ex_bus",    64'(bus.ex_bus),    64'd0);
                check("abort_inst_out",  64'(bus.inst_out),  64'd0);
                check("abort_done",      64'(bus.done),      64'd0);
                check("abort_busy",      64'(bus.busy),      64'd0);
                check("abort_cmd_ready", 64'(bus.cmd_ready), 64'd0);
                rst = 1'b0;
                @(negedge clk);
                check("abort_recover_ready", 64'(bus.cmd_ready), 64'd1);
                check("abort_recover_ex",    64'(bus.ex_bus),    64'd0);
                return;
            end else begin
                if (mode == 0)      sv = 1'b1;
                else if (mode == 1) sv = (k >= 2) && ((k - 2) % 2 == 0);
                else                sv = 1'($urandom_range(0, 1));
                bus.s_valid = sv;
                bus.s_data  = seed + 32'(acc);
                pend = exp_sr && sv;
                pend_idx = acc;
                if (pend) begin
                    acc++;
                    if (acc == len) done_cyc = k + 2;
                end
            end
        end
        if (!finished) check("cycle_budget", 64'd0, 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_base = '0; bus.cmd_len = '0;
        bus.cmd_bg_mask = 4'h0; bus.s_valid = 1'b0; bus.s_data = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("rst_ex_bus",    64'(bus.ex_bus),    64'd0);
        check("rst_inst_out",  64'(bus.inst_out),  64'd0);
        check("rst_busy",      64'(bus.busy),      64'd0);
        check("rst_done",      64'(bus.done),      64'd0);
        check("rst_s_ready",   64'(bus.s_ready),   64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // Directed scenarios.
        run_cmd(1'b0, 32'h010, 4, 4'b0001, 0, 32'hA0, 1'b0, 0);
        run_cmd(1'b0, 32'h155, 3, 4'b0010, 1, $urandom, 1'b0, 0);
        run_cmd(1'b1, 32'h3FE, 4, 4'b1111, 2, 32'h0, 1'b0, 0);
        run_cmd(1'b0, 32'h020, 0, 4'b0101, 0, 32'h0, 1'b0, 0);
        run_cmd(1'b1, 32'h021, 0, 4'b1010, 0, 32'h0, 1'b0, 0);
        run_cmd(1'b0, 32'h100, 8, 4'b0011, 0, 32'hB0, 1'b0, 2);
        run_cmd(1'b0, 32'h100, 8, 4'b0011, 0, 32'hB0, 1'b0, 0);
        run_cmd(1'b0, 32'h200, 5, 4'b1000, 2, 32'hC0, 1'b1, 0);
        run_cmd(1'b0, 32'h200, 5, 4'b1000, 2, 32'hC0, 1'b0, 0);
        run_cmd(1'b0, 32'h3F0, 1024, 4'b1010, 0, $urandom, 1'b0, 0);
        run_cmd(1'b1, 32'h3FF, 1, 4'b0100, 0, 32'h0, 1'b0, 0);

        // Randomized commands.
        for (int i = 0; i < 12; i++) begin
            run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 40)), 4'($urandom_range(0, 15)),
                    int'($urandom_range(0, 2)), $urandom, 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
